// File: rtl/laser_packet_assembler.sv
// ---------------------------------------------------------------------------
// laser_packet_assembler
//
// Frames the laser receiver's per-beat output into packets by header byte,
// counts each packet to its fixed length, forwards START/STOP payload beats
// through a small FIFO as a byte stream (data1 byte first, then data2 byte),
// and reports completion / errors of every packet to the top-level FSM.
//
// Ports:
//   clock       in   system clock
//   reset       in   synchronous active-high reset
//   data_valid  in   one-cycle beat strobe from the receiver
//   data1_in    in   [7:0] laser-1 byte of the beat (carries the header code)
//   data2_in    in   [7:0] laser-2 byte of the beat
//   out_ready   in   downstream (FTDI write side) accepts a byte this cycle
//   out_valid   out  out_data holds a valid byte
//   out_data    out  [7:0] payload byte stream
//   pkt_type    out  [2:0] type of last accepted header (0 none, 1 START,
//                    2 STOP, 3 ACK, 4 FAIL, 5 DONE)
//   pkt_done    out  one-cycle pulse: packet completed cleanly
//   pkt_error   out  one-cycle pulse: bad header, gap timeout or dropped beat
//   overflow    out  sticky: a payload beat was dropped on a full FIFO
//
// Build option:
//   LASER_HDR_MATCH_EN  when defined, a header beat is accepted only if
//                       data2_in repeats data1_in.
// ---------------------------------------------------------------------------
module laser_packet_assembler #(
    parameter int DEPTH       = 16,
    parameter int START_LEN   = 256,
    parameter int STOP_LEN    = 3,
    parameter int CTRL_LEN    = 2,
    parameter int GAP_TIMEOUT = 40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [7:0] data1_in,
    input  logic [7:0] data2_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [2:0] pkt_type,
    output logic       pkt_done,
    output logic       pkt_error,
    output logic       overflow
);

    localparam int AW      = $clog2(DEPTH);
    localparam int MAX_LEN = (START_LEN > STOP_LEN)
                           ? ((START_LEN > CTRL_LEN) ? START_LEN : CTRL_LEN)
                           : ((STOP_LEN  > CTRL_LEN) ? STOP_LEN  : CTRL_LEN);
    localparam int BW      = $clog2(MAX_LEN + 1);
    localparam int GW      = $clog2(GAP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_START = 3'd1,
        PKT_STOP  = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_FAIL  = 3'd4,
        PKT_DONE  = 3'd5
    } pkt_kind_e;

    typedef enum logic {IDLE, COLLECT} state_e;

    function automatic pkt_kind_e decode_header(input logic [7:0] code);
        case (code)
            8'hcc:   return PKT_START;
            8'h55:   return PKT_STOP;
            8'h11:   return PKT_ACK;
            8'hbb:   return PKT_FAIL;
            8'haa:   return PKT_DONE;
            default: return PKT_NONE;
        endcase
    endfunction

    function automatic logic [BW-1:0] pkt_len(input pkt_kind_e kind);
        case (kind)
            PKT_START: return BW'(START_LEN);
            PKT_STOP:  return BW'(STOP_LEN);
            default:   return BW'(CTRL_LEN);
        endcase
    endfunction

    state_e          state;
    pkt_kind_e       cur_type;
    logic [BW-1:0]   beat_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            dropped;

    pkt_kind_e       hdr_type;
    logic            hdr_ok;
    logic            push_req;
    logic            push_ok;
    logic            drop_now;
    logic            pop;
    logic            fifo_full;
    logic            last_beat;

    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fifo_cnt;
    logic            ser_valid;
    logic            ser_sel;
    logic [15:0]     ser_data;

    assign hdr_type = decode_header(data1_in);
`ifdef LASER_HDR_MATCH_EN
    assign hdr_ok   = (hdr_type != PKT_NONE) && (data2_in == data1_in);
`else
    assign hdr_ok   = (hdr_type != PKT_NONE);
`endif

    // The beat held by the serializer still occupies its FIFO slot; the slot
    // is retired (pop) only when the data2 byte leaves, so DEPTH counts every
    // beat not yet fully transmitted.
    assign fifo_full = (fifo_cnt == (AW+1)'(DEPTH));
    assign pop       = ser_valid && ser_sel && out_ready;
    assign push_req  = (state == COLLECT) && data_valid
                     && ((cur_type == PKT_START) || (cur_type == PKT_STOP));
    assign push_ok   = push_req && (!fifo_full || pop);
    assign drop_now  = push_req && !push_ok;
    assign last_beat = (beat_cnt == pkt_len(cur_type) - BW'(1));

    assign out_valid = ser_valid;
    assign out_data  = ser_sel ? ser_data[7:0] : ser_data[15:8];
    assign pkt_type  = cur_type;

    // Packet framing FSM with registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cur_type  <= PKT_NONE;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            dropped   <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_error <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values; the default pulse clears
            // below are overridden by later assignments in the same block.
            pkt_done  <= 1'b0;
            pkt_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        if (hdr_ok) begin
                            cur_type <= hdr_type;
                            beat_cnt <= BW'(1);
                            gap_cnt  <= '0;
                            dropped  <= 1'b0;
                            state    <= COLLECT;
                        end else begin
                            pkt_error <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (data_valid) begin
                        // A beat arriving on the expiry cycle still wins.
                        gap_cnt  <= '0;
                        beat_cnt <= beat_cnt + BW'(1);
                        dropped  <= dropped | drop_now;
                        if (drop_now) begin
                            overflow <= 1'b1;
                        end
                        if (last_beat) begin
                            state <= IDLE;
                            if (dropped || drop_now) begin
                                pkt_error <= 1'b1;
                            end else begin
                                pkt_done  <= 1'b1;
                            end
                        end
                    end else if (gap_cnt == GW'(GAP_TIMEOUT - 1)) begin
                        // Queued payload is kept; only the framing aborts.
                        pkt_error <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count define
    // which entries are meaningful, so clearing the array buys nothing.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= {data1_in, data2_in};
        end
    end

    // FIFO pointers and the two-byte serializer that reads the head entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            ser_valid <= 1'b0;
            ser_sel   <= 1'b0;
            ser_data  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_cnt <= fifo_cnt + (AW+1)'(push_ok) - (AW+1)'(pop);

            if (pop) begin
                // Load the following entry on the same edge: no bubble.
                ser_sel <= 1'b0;
                if (fifo_cnt > (AW+1)'(1)) begin
                    ser_data  <= mem[rd_ptr + AW'(1)];
                    ser_valid <= 1'b1;
                end else begin
                    ser_valid <= 1'b0;
                end
            end else if (!ser_valid && (fifo_cnt != '0)) begin
                ser_data  <= mem[rd_ptr];
                ser_valid <= 1'b1;
                ser_sel   <= 1'b0;
            end else if (ser_valid && out_ready) begin
                ser_sel <= 1'b1;
            end
        end
    end

endmodule

// File: doc/laser_packet_assembler.md
Name: laser_packet_assembler

Overview:
- Downstream of the laser receiver. Consumes its per-beat output: a `data_valid` pulse plus one byte from each laser.
- Frames beats into packets by header byte and counts each packet to its fixed length.
- Forwards payload bytes of data packets (START/STOP) through a small FIFO as a byte stream toward the FTDI write side.
- Reports control packets (ACK/FAIL/DONE), completion and errors to the top-level FSM.

Parameters:
- DEPTH, 16: FIFO depth in beats (byte pairs); power of two.
- START_LEN, 256: START packet length in beats, header beat included.
- STOP_LEN, 3: STOP packet length in beats, header included.
- CTRL_LEN, 2: ACK/FAIL/DONE packet length in beats, header included.
- GAP_TIMEOUT, 40: max idle cycles between beats inside a packet.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- data_valid  input  1  one-cycle beat strobe from the receiver.
- data1_in  input  8  laser-1 byte of the beat.
- data2_in  input  8  laser-2 byte of the beat.
- out_ready  input  1  FTDI side can accept a byte this cycle.
- out_valid  output  1  out_data holds a valid byte.
- out_data  output  8  payload byte stream; data1 byte first, then data2 byte.
- pkt_type  output  3  type of last header: 0 none, 1 START, 2 STOP, 3 ACK, 4 FAIL, 5 DONE.
- pkt_done  output  1  one-cycle pulse: packet completed cleanly.
- pkt_error  output  1  one-cycle pulse: bad header, timeout or overflow.
- overflow  output  1  sticky: a beat was dropped because the FIFO was full.

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset: state IDLE; FIFO empty; serializer empty; beat and gap counters 0.
  - Outputs: out_valid=0, out_data=0, pkt_type=0, pkt_done=0, pkt_error=0, overflow=0.
  - Reset asserted mid-packet discards the partial packet and all queued bytes.
- Header codes: START=8'hcc, STOP=8'h55, ACK=8'h11, FAIL=8'hbb, DONE=8'haa, taken from data1_in.
- FSM states: IDLE, COLLECT.
- IDLE, beat arrives:
  - Known header: register pkt_type, set beat count to 1, go to COLLECT.
  - Header beat is never forwarded to the FIFO.
  - Unknown header: pkt_error pulse the next cycle, stay IDLE, pkt_type unchanged.
- Packet length L: START_LEN, STOP_LEN or CTRL_LEN according to type.
- COLLECT, each beat:
  - START/STOP: push {data1_in, data2_in} to the FIFO.
  - ACK/FAIL/DONE: beat is counted only, never pushed.
  - Beat count increments. When the beat arriving is beat number L: go to IDLE and pulse pkt_done the next cycle; if a beat was dropped in this packet, pulse pkt_error instead.
- Gap timer (COLLECT only):
  - Cleared on every beat, otherwise increments.
  - Reaching GAP_TIMEOUT: pulse pkt_error, go to IDLE, keep already-queued bytes.
  - data_valid in the same cycle the timer would expire: the beat wins and the timer clears.
- FIFO full when a payload beat arrives: the beat is dropped, overflow sets (cleared only by reset), and the beat still counts toward L.
- Simultaneous push and pop when full: the pop frees a slot first, so the push succeeds.
- Serializer:
  - Holds one beat, emits data1 then data2.
  - A byte transfers on out_valid && out_ready.
  - The next beat is popped in the same cycle the second byte transfers, giving no bubble.
  - out_data is stable while out_valid && !out_ready.
- Latency: beat pushed at edge N into an empty FIFO/serializer gives out_valid=1 at edge N+1 with the data1 byte.
- Pulses: pkt_done and pkt_error are never high together, and each is high exactly one cycle.

Optional Feature:
- Macro: LASER_HDR_MATCH_EN.
- Defined: a header beat is accepted only if data2_in == data1_in. On mismatch, pulse pkt_error and stay IDLE.
- Undefined: data2_in of the header beat is ignored.

Test Plan:
- ACK beat {11,11} then beat {00,00} 3 cycles later -> pkt_type=3, one pkt_done pulse, out_valid stays 0.
- STOP: {55,55},{A1,A2},{B1,B2} with out_ready=1 -> out_data A1,A2,B1,B2 on consecutive cycles, pkt_done once, pkt_type=2.
- Header {cc,cc}, one payload beat, then 40 idle cycles -> pkt_error pulse, state IDLE; a following ACK packet completes normally.
- Header {7e,7e} -> pkt_error, no FIFO write; with LASER_HDR_MATCH_EN, header {cc,55} -> pkt_error, pkt_type stays at its prior value.
- START with out_ready=0 throughout: first 16 payload beats queue, 17th dropped -> overflow=1; at beat 256, pkt_error instead of pkt_done; first 32 bytes drain intact once out_ready=1.
- Reset asserted mid-START with 5 beats queued -> next cycle out_valid=0, overflow=0, pkt_type=0; next header is treated as a new packet.
